// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS controller: state encodings,
// opcode/funct values, ALU operation classes and ALU control codes.
package mips_ctrl_pkg;

    localparam int OPW = 6;
    localparam int STW = 4;

    localparam logic [STW-1:0] S_FETCH   = 4'd0;
    localparam logic [STW-1:0] S_DECODE  = 4'd1;
    localparam logic [STW-1:0] S_MEMADR  = 4'd2;
    localparam logic [STW-1:0] S_MEMRD   = 4'd3;
    localparam logic [STW-1:0] S_MEMWB   = 4'd4;
    localparam logic [STW-1:0] S_MEMWR   = 4'd5;
    localparam logic [STW-1:0] S_RTYPEEX = 4'd6;
    localparam logic [STW-1:0] S_RTYPEWB = 4'd7;
    localparam logic [STW-1:0] S_BEQEX   = 4'd8;
    localparam logic [STW-1:0] S_ADDIEX  = 4'd9;
    localparam logic [STW-1:0] S_ADDIWB  = 4'd10;
    localparam logic [STW-1:0] S_JEX     = 4'd11;

    localparam logic [OPW-1:0] OP_LW    = 6'b100011;
    localparam logic [OPW-1:0] OP_SW    = 6'b101011;
    localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPW-1:0] OP_J     = 6'b000010;

    localparam logic [OPW-1:0] F_ADD = 6'b100000;
    localparam logic [OPW-1:0] F_SUB = 6'b100010;
    localparam logic [OPW-1:0] F_AND = 6'b100100;
    localparam logic [OPW-1:0] F_OR  = 6'b100101;
    localparam logic [OPW-1:0] F_SLT = 6'b101010;

    // ALUOP_NONE is only used by unencoded states so the ALU control reads 000.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_NONE  = 2'b11
    } aluop_e;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mips_multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction fields and flag in, enables and
// mux selects out. Level signals only, no handshake; state is a debug tap.
interface mips_multicycle_controller_if;
    import mips_ctrl_pkg::*;

    logic [OPW-1:0] op;
    logic [OPW-1:0] funct;
    logic           zero;
    logic           pcen;
    logic           memwrite;
    logic           irwrite;
    logic           regwrite;
    logic           alusrca;
    logic [1:0]     alusrcb;
    logic           iord;
    logic           memtoreg;
    logic           regdst;
    logic [1:0]     pcsrc;
    logic [2:0]     alucontrol;
    logic           illegal;
    logic [STW-1:0] state;

    modport master (
        input  op, funct, zero,
        output pcen, memwrite, irwrite, regwrite, alusrca, alusrcb, iord,
               memtoreg, regdst, pcsrc, alucontrol, illegal, state
    );

    modport slave (
        output op, funct, zero,
        input  pcen, memwrite, irwrite, regwrite, alusrca, alusrcb, iord,
               memtoreg, regdst, pcsrc, alucontrol, illegal, state
    );

endinterface

// File: rtl/mips_aludec.sv
// Combinational ALU decoder: maps the controller's ALU operation class and the
// R-type funct field to the 3-bit ALU control code.
module mips_aludec
    import mips_ctrl_pkg::*;
(
    input  aluop_e         aluop_i,
    input  logic [OPW-1:0] funct_i,
    output logic [2:0]     alucontrol_o
);

    always_comb begin
        alucontrol_o = ALU_ADD;
        case (aluop_i)
            ALUOP_ADD:  alucontrol_o = ALU_ADD;
            ALUOP_SUB:  alucontrol_o = ALU_SUB;
            ALUOP_NONE: alucontrol_o = ALU_AND;
            ALUOP_FUNCT: begin
                case (funct_i)
                    F_ADD:   alucontrol_o = ALU_ADD;
                    F_SUB:   alucontrol_o = ALU_SUB;
                    F_AND:   alucontrol_o = ALU_AND;
                    F_OR:    alucontrol_o = ALU_OR;
                    F_SLT:   alucontrol_o = ALU_SLT;
                    default: alucontrol_o = ALU_ADD;
                endcase
            end
            default:    alucontrol_o = ALU_AND;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Moore main-decoder FSM for the multicycle MIPS datapath; one state per clock,
// outputs depend only on state (plus op in DECODE for the illegal pulse).
module mips_multicycle_controller
    import mips_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    mips_multicycle_controller_if.master ctrl
);

    logic [STW-1:0] state_q, state_d;
    logic           pcwrite, branch;
    aluop_e         aluop;
    logic           memwrite, irwrite, regwrite, alusrca, iord;
    logic           memtoreg, regdst, illegal;
    logic [1:0]     alusrcb, pcsrc;
    logic [2:0]     alucontrol;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = S_FETCH;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        aluop    = ALUOP_ADD;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        iord     = 1'b0;
        memtoreg = 1'b0;
        regdst   = 1'b0;
        pcsrc    = 2'b00;
        illegal  = 1'b0;
        case (state_q)
            S_FETCH: begin
                irwrite = 1'b1;
                alusrcb = 2'b01;
                pcwrite = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is computed here so BEQEX can use ALUOut.
                alusrcb = 2'b11;
                case (ctrl.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    default:      illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (ctrl.op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
                state_d = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BEQEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                branch  = 1'b1;
                pcsrc   = 2'b01;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: regwrite = 1'b1;
            S_JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: aluop = ALUOP_NONE;
        endcase
    end

    mips_aludec u_aludec (
        .aluop_i      (aluop),
        .funct_i      (ctrl.funct),
        .alucontrol_o (alucontrol)
    );

    assign ctrl.pcen       = pcwrite | (branch & ctrl.zero);
    assign ctrl.memwrite   = memwrite;
    assign ctrl.irwrite    = irwrite;
    assign ctrl.regwrite   = regwrite;
    assign ctrl.alusrca    = alusrca;
    assign ctrl.alusrcb    = alusrcb;
    assign ctrl.iord       = iord;
    assign ctrl.memtoreg   = memtoreg;
    assign ctrl.regdst     = regdst;
    assign ctrl.pcsrc      = pcsrc;
    assign ctrl.alucontrol = alucontrol;
    assign ctrl.illegal    = illegal;
    assign ctrl.state      = state_q;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Directed plus randomized instruction streams against a per-instruction
// phase-list model of the controller's outputs.
module tb_mips_multicycle_controller;
    import mips_ctrl_pkg::*;

    typedef enum {P_F, P_D, P_MA, P_MR, P_MWB, P_MW, P_RE, P_RW, P_BE, P_AE, P_AW, P_J} phase_t;

    typedef struct packed {
        logic       pcen;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic [1:0] pcsrc;
        logic [2:0] alucontrol;
        logic       illegal;
    } ctl_t;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    mips_multicycle_controller_if bus ();

    mips_multicycle_controller dut (
        .clk   (clk),
        .reset (reset),
        .ctrl  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int seq_len(logic [5:0] op);
        case (op)
            6'b100011: return 5;
            6'b101011: return 4;
            6'b000000: return 4;
            6'b000100: return 3;
            6'b001000: return 4;
            6'b000010: return 3;
            default:   return 2;
        endcase
    endfunction

    function automatic phase_t phase_at(logic [5:0] op, int i);
        if (i == 0) return P_F;
        if (i == 1) return P_D;
        case (op)
            6'b100011: return (i == 2) ? P_MA : ((i == 3) ? P_MR : P_MWB);
            6'b101011: return (i == 2) ? P_MA : P_MW;
            6'b000000: return (i == 2) ? P_RE : P_RW;
            6'b000100: return P_BE;
            6'b001000: return (i == 2) ? P_AE : P_AW;
            6'b000010: return P_J;
            default:   return P_F;
        endcase
    endfunction

    function automatic logic [2:0] alu_of(logic [5:0] funct);
        case (funct)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic ctl_t exp_ctl(phase_t p, logic [5:0] op, logic [5:0] funct, logic z);
        ctl_t e;
        e = '0;
        e.alucontrol = 3'b010;
        case (p)
            P_F:   begin e.pcen = 1'b1; e.irwrite = 1'b1; e.alusrcb = 2'b01; end
            P_D:   begin e.alusrcb = 2'b11; e.illegal = (seq_len(op) == 2); end
            P_MA:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            P_MR:  e.iord = 1'b1;
            P_MWB: begin e.memtoreg = 1'b1; e.regwrite = 1'b1; end
            P_MW:  begin e.iord = 1'b1; e.memwrite = 1'b1; end
            P_RE:  begin e.alusrca = 1'b1; e.alucontrol = alu_of(funct); end
            P_RW:  begin e.regdst = 1'b1; e.regwrite = 1'b1; end
            P_BE:  begin e.alusrca = 1'b1; e.alucontrol = 3'b110; e.pcsrc = 2'b01; e.pcen = z; end
            P_AE:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            P_AW:  e.regwrite = 1'b1;
            P_J:   begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic logic [STW-1:0] state_of(phase_t p);
        case (p)
            P_F:   return S_FETCH;
            P_D:   return S_DECODE;
            P_MA:  return S_MEMADR;
            P_MR:  return S_MEMRD;
            P_MWB: return S_MEMWB;
            P_MW:  return S_MEMWR;
            P_RE:  return S_RTYPEEX;
            P_RW:  return S_RTYPEWB;
            P_BE:  return S_BEQEX;
            P_AE:  return S_ADDIEX;
            P_AW:  return S_ADDIWB;
            default: return S_JEX;
        endcase
    endfunction

    // ---------------- checking ----------------
    function automatic ctl_t sample();
        ctl_t o;
        o.pcen       = bus.pcen;
        o.memwrite   = bus.memwrite;
        o.irwrite    = bus.irwrite;
        o.regwrite   = bus.regwrite;
        o.alusrca    = bus.alusrca;
        o.alusrcb    = bus.alusrcb;
        o.iord       = bus.iord;
        o.memtoreg   = bus.memtoreg;
        o.regdst     = bus.regdst;
        o.pcsrc      = bus.pcsrc;
        o.alucontrol = bus.alucontrol;
        o.illegal    = bus.illegal;
        return o;
    endfunction

    task automatic check_ctl(string tag, ctl_t exp);
        ctl_t obs;
        obs = sample();
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s ctl: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_state(string tag, logic [STW-1:0] exp);
        vectors++;
        assert (bus.state === exp) else begin
            miscompares++;
            $error("FAIL %s state: observed %0d expected %0d", tag, bus.state, exp);
        end
    endtask

    // zsel: -1 random zero flag, otherwise forced value
    task automatic step(phase_t p, logic [5:0] op, logic [5:0] funct, int zsel);
        logic  z;
        string tag;
        z = (zsel < 0) ? 1'($urandom_range(0, 1)) : 1'(zsel);
        bus.zero = z;
        @(negedge clk);
        tag = $sformatf("op%b f%b %s", op, funct, p.name());
        check_ctl(tag, exp_ctl(p, op, funct, z));
        check_state(tag, state_of(p));
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(logic [5:0] op, logic [5:0] funct, int zsel);
        bus.op    = op;
        bus.funct = funct;
        for (int i = 0; i < seq_len(op); i++) step(phase_at(op, i), op, funct, zsel);
    endtask

    logic [5:0] legal_ops [6];
    logic [5:0] functs [5];

    initial begin
        logic [5:0] op, fn;
        ctl_t fetch_ctl;
        vectors     = 0;
        miscompares = 0;
        legal_ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
        functs    = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        fetch_ctl = exp_ctl(P_F, 6'b0, 6'b0, 1'b0);

        reset    = 1'b1;
        bus.op   = 6'($urandom_range(0, 63));
        bus.funct = 6'($urandom_range(0, 63));
        bus.zero = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_ctl("in_reset", fetch_ctl);
            check_state("in_reset", S_FETCH);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;

        // directed
        run_instr(6'b100011, 6'b000000, -1);
        run_instr(6'b101011, 6'b000000, -1);
        run_instr(6'b000000, 6'b101010, -1);
        run_instr(6'b000100, 6'b000000, 1);
        run_instr(6'b000100, 6'b000000, 0);
        run_instr(6'b111111, 6'b000000, -1);
        run_instr(6'b000000, 6'b111111, -1);
        run_instr(6'b001000, 6'b000000, -1);
        run_instr(6'b000010, 6'b000000, -1);

        // randomized
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 9) < 8) op = legal_ops[$urandom_range(0, 5)];
            else                          op = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) fn = functs[$urandom_range(0, 4)];
            else                           fn = 6'($urandom_range(0, 63));
            run_instr(op, fn, -1);
        end

        // reset asserted in the middle of a store
        bus.op    = 6'b101011;
        bus.funct = 6'b000000;
        step(P_F, 6'b101011, 6'b0, -1);
        step(P_D, 6'b101011, 6'b0, -1);
        step(P_MA, 6'b101011, 6'b0, -1);
        bus.zero = 1'b0;
        @(negedge clk);
        check_ctl("memwr_before_reset", exp_ctl(P_MW, 6'b101011, 6'b0, 1'b0));
        #2;
        reset = 1'b1;
        #1;
        check_ctl("async_reset", fetch_ctl);
        check_state("async_reset", S_FETCH);
        @(posedge clk);
        @(negedge clk);
        check_ctl("reset_held", fetch_ctl);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_instr(6'b100011, 6'b000000, -1);
        run_instr(6'b000000, 6'b100010, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
